// File: rtl/riscv_v_div_if.sv
// riscv_v_div_if: operation/result handshake bundle for the serial vector divider.
// Ports (signals): in_valid/in_ready accept handshake, is_signed, is_rem,
// osize_vector (one-hot element size), srca/srcb operand vectors,
// out_valid/out_ready result handshake, result vector.
// master modport drives operations; slave modport is the divider.
interface riscv_v_div_if #(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_OSIZES = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  is_signed;
   logic                  is_rem;
   logic [NUM_OSIZES-1:0] osize_vector;
   logic [DATA_WIDTH-1:0] srca;
   logic [DATA_WIDTH-1:0] srcb;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] result;
   modport master (
      output in_valid, is_signed, is_rem, osize_vector, srca, srcb, out_ready,
      input  in_ready, out_valid, result
   );
   modport slave (
      input  in_valid, is_signed, is_rem, osize_vector, srca, srcb, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/riscv_v_div.sv
// riscv_v_div: element-serial vector integer divider on one restoring radix-2 datapath.
// Ports: clk, rst_n (synchronous, active-low), bus (riscv_v_div_if.slave):
// accept handshake with operands and controls, result handshake with result vector.
// Optional macro RISCV_V_DIV_EARLY_ZERO_EN: elements with a zero divisor skip ITER.
module riscv_v_div #(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_OSIZES = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   riscv_v_div_if.slave bus
);
   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam int KW = (NUM_OSIZES > 1) ? $clog2(NUM_OSIZES) : 1;
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
   state_t st, st_nx;
   logic [DATA_WIDTH-1:0] a_r, b_r, dvd, dsr, rmd, quo, res;
   logic [DATA_WIDTH-1:0] mask, ea, eb, ma, mb, fix_val;
   logic [DATA_WIDTH:0]   trial;
   logic                  sgn_r, rem_r, qneg, rneg, bz, sa, sb, ge;
   logic [KW-1:0]         k_r, k_in;
   logic [CW-1:0]         cnt, idx, w, off;
   // lowest set bit wins; all-zero falls back to 8-bit elements
   always_comb begin
      k_in = '0;
      for (int j = NUM_OSIZES - 1; j >= 0; j--)
         if (bus.osize_vector[j]) k_in = KW'(j);
   end
   // shifting by DATA_WIDTH yields 0, so the full-width mask falls out as all-ones
   always_comb begin
      w       = CW'(8) << k_r;
      mask    = (DATA_WIDTH'(1) << w) - DATA_WIDTH'(1);
      off     = idx * w;
      ea      = (a_r >> off) & mask;
      eb      = (b_r >> off) & mask;
      sa      = sgn_r && (ea > (mask >> 1));
      sb      = sgn_r && (eb > (mask >> 1));
      ma      = sa ? ((-ea) & mask) : ea;
      mb      = sb ? ((-eb) & mask) : eb;
      trial   = {rmd, dvd[DATA_WIDTH-1]};
      ge      = trial >= {1'b0, dsr};
      fix_val = mask & (bz ? (rem_r ? ea : mask) :
                        rem_r ? (rneg ? -rmd : rmd) : (qneg ? -quo : quo));
   end
   always_comb begin
      st_nx = st;
      case (st)
         IDLE: if (bus.in_valid) st_nx = PREP;
`ifdef RISCV_V_DIV_EARLY_ZERO_EN
         PREP: st_nx = (eb == '0) ? FIX : ITER;
`else
         PREP: st_nx = ITER;
`endif
         ITER: if (cnt == CW'(1)) st_nx = FIX;
         FIX:  st_nx = (off + w == CW'(DATA_WIDTH)) ? DONE : PREP;
         DONE: if (bus.out_ready) st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nx;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         sgn_r <= 1'b0;
         rem_r <= 1'b0;
         k_r   <= '0;
         idx   <= '0;
         cnt   <= '0;
         dvd   <= '0;
         dsr   <= '0;
         rmd   <= '0;
         quo   <= '0;
         qneg  <= 1'b0;
         rneg  <= 1'b0;
         bz    <= 1'b0;
         res   <= '0;
      end else begin
         case (st)
            IDLE: if (bus.in_valid) begin
               a_r   <= bus.srca;
               b_r   <= bus.srcb;
               sgn_r <= bus.is_signed;
               rem_r <= bus.is_rem;
               k_r   <= k_in;
               idx   <= '0;
            end
            PREP: begin
               // left-align the dividend so each ITER consumes the top bit
               dvd  <= ma << (CW'(DATA_WIDTH) - w);
               dsr  <= mb;
               rmd  <= '0;
               quo  <= '0;
               qneg <= sa ^ sb;
               rneg <= sa;
               bz   <= (eb == '0);
               cnt  <= w;
            end
            ITER: begin
               rmd <= ge ? DATA_WIDTH'(trial - {1'b0, dsr}) : trial[DATA_WIDTH-1:0];
               dvd <= dvd << 1;
               quo <= {quo[DATA_WIDTH-2:0], ge};
               cnt <= cnt - CW'(1);
            end
            FIX: begin
               res <= (res & ~(mask << off)) | (fix_val << off);
               idx <= idx + CW'(1);
            end
            default: ;
         endcase
      end
   end
   assign bus.in_ready  = (st == IDLE);
   assign bus.out_valid = (st == DONE);
   assign bus.result    = res;
endmodule

// File: tb/tb_riscv_v_div.sv
// tb_riscv_v_div: directed and randomized checks of riscv_v_div against an arithmetic model.
module tb_riscv_v_div;
   logic clk;
   logic rst_n;
   int   checks;
   int   fails;
   riscv_v_div_if #(.DATA_WIDTH(128), .NUM_OSIZES(5)) bus ();
   riscv_v_div #(.DATA_WIDTH(128), .NUM_OSIZES(5)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction
   function automatic logic [127:0] lane_mask(input int k);
      int w;
      w = 8 << k;
      return (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
   endfunction
   function automatic logic [127:0] model(input int k, input bit sg, input bit rm,
                                          input logic [127:0] a, input logic [127:0] b);
      int w;
      logic [127:0] m, ua, ub, r, acc;
      logic [128:0] ta, tb;
      logic signed [128:0] qs, rs;
      w   = 8 << k;
      m   = lane_mask(k);
      acc = '0;
      for (int e = 0; e < 128 / w; e++) begin
         ua = (a >> (e * w)) & m;
         ub = (b >> (e * w)) & m;
         if (ub == '0) r = rm ? ua : m;
         else if (!sg) r = rm ? (ua % ub) : (ua / ub);
         else begin
            ta = {1'b0, ua};
            tb = {1'b0, ub};
            if (((ua >> (w - 1)) & 128'd1) != '0) ta = ta - (129'd1 << w);
            if (((ub >> (w - 1)) & 128'd1) != '0) tb = tb - (129'd1 << w);
            qs = $signed(ta) / $signed(tb);
            rs = $signed(ta) % $signed(tb);
            r  = rm ? rs[127:0] : qs[127:0];
         end
         acc = acc | ((r & m) << (e * w));
      end
      return acc;
   endfunction
   function automatic int exp_lat(input int k, input logic [127:0] b);
      int w, sum;
      w   = 8 << k;
      sum = 0;
      for (int e = 0; e < 128 / w; e++) begin
`ifdef RISCV_V_DIV_EARLY_ZERO_EN
         sum += (((b >> (e * w)) & lane_mask(k)) == '0) ? 2 : w + 2;
`else
         sum += w + 2;
`endif
      end
      return sum;
   endfunction
   task automatic run_op(input logic [4:0] osz, input bit sg, input bit rm,
                         input logic [127:0] a, input logic [127:0] b, input int hold,
                         output logic [127:0] got, output int lat);
      @(negedge clk);
      bus.osize_vector = osz;
      bus.is_signed    = sg;
      bus.is_rem       = rm;
      bus.srca         = a;
      bus.srcb         = b;
      bus.in_valid     = 1'b1;
      chk("in_ready_before_accept", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid     = 1'b0;
      bus.srca         = rnd128();
      bus.srcb         = rnd128();
      bus.is_signed    = 1'($urandom_range(0, 1));
      bus.is_rem       = 1'($urandom_range(0, 1));
      bus.osize_vector = 5'($urandom());
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 400);
      got = bus.result;
      repeat (hold) begin
         @(posedge clk);
         #1;
         chk("hold_result_stable", bus.result, got);
         chk("hold_in_ready_low", bus.in_ready, 0);
         chk("hold_out_valid_high", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("post_handshake_in_ready", bus.in_ready, 1);
      chk("post_handshake_out_valid", bus.out_valid, 0);
   endtask
   initial begin
      logic [127:0] got, a, b, m;
      int           lat, k, stale;
      bit           sg, rm;
      checks = 0;
      fails  = 0;
      rst_n  = 1'b0;
      bus.in_valid     = 1'b0;
      bus.out_ready    = 1'b0;
      bus.is_signed    = 1'b0;
      bus.is_rem       = 1'b0;
      bus.osize_vector = '0;
      bus.srca         = '0;
      bus.srcb         = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", bus.in_ready, 1);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_result", bus.result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(5'b00001, 0, 0, {16{8'h64}}, {16{8'h07}}, 0, got, lat);
      chk("u8_quotient", got, {16{8'h0E}});
      chk("u8_latency", lat, 160);
      run_op(5'b00100, 1, 0, {4{32'hFFFFFFF9}}, {4{32'h00000002}}, 0, got, lat);
      chk("s32_quotient", got, {4{32'hFFFFFFFD}});
      chk("s32_latency", lat, 136);
      run_op(5'b00100, 1, 1, {4{32'hFFFFFFF9}}, {4{32'h00000002}}, 0, got, lat);
      chk("s32_remainder", got, {4{32'hFFFFFFFF}});
      run_op(5'b00010, 0, 0, {8{16'h1234}}, '0, 0, got, lat);
      chk("div0_quotient", got, {8{16'hFFFF}});
      chk("div0_latency", lat, exp_lat(1, '0));
      run_op(5'b00010, 1, 1, {8{16'h1234}}, '0, 0, got, lat);
      chk("div0_remainder", got, {8{16'h1234}});
      run_op(5'b01000, 1, 0, {2{64'h8000000000000000}}, {128{1'b1}}, 5, got, lat);
      chk("ovf64_quotient", got, {2{64'h8000000000000000}});
      chk("ovf64_latency", lat, 132);
      run_op(5'b01000, 1, 1, {2{64'h8000000000000000}}, {128{1'b1}}, 0, got, lat);
      chk("ovf64_remainder", got, 0);
      a = rnd128();
      b = rnd128();
      run_op(5'b10000, 1, 0, a, b, 0, got, lat);
      chk("s128_quotient", got, model(4, 1, 0, a, b));
      chk("s128_latency", lat, exp_lat(4, b));
      a = rnd128();
      b = rnd128() >> 60;
      run_op(5'b10110, 0, 1, a, b, 0, got, lat);
      chk("nonhot_osize_result", got, model(1, 0, 1, a, b));
      chk("nonhot_osize_latency", lat, exp_lat(1, b));
      a = rnd128();
      b = rnd128() >> 100;
      run_op(5'b00000, 1, 0, a, b, 0, got, lat);
      chk("zero_osize_result", got, model(0, 1, 0, a, b));
      chk("zero_osize_latency", lat, exp_lat(0, b));
      for (int i = 0; i < 16; i++) begin
         k  = $urandom_range(0, 4);
         sg = 1'($urandom_range(0, 1));
         rm = 1'($urandom_range(0, 1));
         a  = rnd128();
         b  = rnd128();
         m  = lane_mask(k);
         if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 127);
         if ($urandom_range(0, 3) == 0) begin
            a  = (a & ~m) | (128'd1 << ((8 << k) - 1));
            b  = b | m;
            sg = 1'b1;
         end
         run_op(5'(1 << k), sg, rm, a, b, 0, got, lat);
         chk("random_result", got, model(k, sg, rm, a, b));
         chk("random_latency", lat, exp_lat(k, b));
      end
      @(negedge clk);
      bus.osize_vector = 5'b00001;
      bus.is_signed    = 1'b0;
      bus.is_rem       = 1'b0;
      bus.srca         = {16{8'h64}};
      bus.srcb         = {16{8'h07}};
      bus.in_valid     = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (49) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      chk("abort_result", bus.result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      repeat (200) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) stale++;
      end
      chk("abort_no_stale_valid", stale, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/riscv_v_div.md
RISCV_V_DIV -- requirements
Module: riscv_v_div

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: vector register width in bits.
REQ-002 SHALL have parameter NUM_OSIZES, default 5: number of element-size encodings (8/16/32/64/128 bit).
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: operands and controls are valid.
REQ-006 SHALL have port in_ready  output  1: block accepts an operation.
REQ-007 SHALL have port is_signed  input  1: signed (1) or unsigned (0) division.
REQ-008 SHALL have port is_rem  input  1: return remainder (1) or quotient (0).
REQ-009 SHALL have port osize_vector  input  NUM_OSIZES: one-hot element size; bit k selects 8*2^k bits.
REQ-010 SHALL have port srca  input  DATA_WIDTH: dividend vector.
REQ-011 SHALL have port srcb  input  DATA_WIDTH: divisor vector.
REQ-012 SHALL have port out_valid  output  1: result is valid.
REQ-013 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-014 SHALL have port result  output  DATA_WIDTH: per-element quotient or remainder.

Function
REQ-015 SHALL capture all inputs when in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-016 SHALL resolve a non-one-hot osize_vector to its lowest set bit; an all-zero osize_vector SHALL select 8-bit elements.
REQ-017 SHALL use FSM states IDLE -> PREP -> ITER -> FIX -> (PREP for the next element | DONE) -> IDLE.
REQ-018 SHALL process elements serially, starting at element 0 (LSBs), using one shared DATA_WIDTH-bit restoring radix-2 datapath.
REQ-019 PREP, one cycle: SHALL take magnitudes of the operands when is_signed, and latch the quotient sign (sign a XOR sign b) and the remainder sign (sign a).
REQ-020 ITER, exactly W cycles for element width W: SHALL produce one quotient bit per cycle, MSB first, using a log2(DATA_WIDTH)+1-bit iteration counter.
REQ-021 FIX, one cycle: SHALL apply two's-complement sign correction and write the selected result into element slot i of the result register.
REQ-022 Per-element latency SHALL be W+2 cycles. out_valid SHALL rise N*(W+2) cycles after the accept edge, where N = DATA_WIDTH/W (8-bit: 160, 128-bit: 130).
REQ-023 Divisor zero SHALL give quotient all-ones(W) and remainder equal to the dividend, with no exception signalled.
REQ-024 Signed overflow (dividend = -2^(W-1), divisor = -1) SHALL give quotient equal to the dividend and remainder 0.
REQ-025 In DONE, out_valid SHALL be 1, and result SHALL stay stable until out_ready; the state SHALL return to IDLE on the edge where out_valid && out_ready.
REQ-026 in_ready SHALL first be 1 in the cycle after the output handshake; back-to-back throughput SHALL be one operation per (latency + 2) cycles.
REQ-027 in_valid, operands and out_ready SHALL be ignored outside IDLE/DONE as applicable; changing the inputs mid-operation SHALL NOT affect the result.

Reset
REQ-028 When rst_n = 0 at a clock edge, the block SHALL enter IDLE, regardless of state, aborting any operation in progress.
REQ-029 Reset values SHALL be: in_ready = 1, out_valid = 0, result = 0, iteration counter = 0, element index = 0.
REQ-030 An aborted operation SHALL produce no out_valid pulse after reset.

Configuration
REQ-031 Macro RISCV_V_DIV_EARLY_ZERO_EN SHALL control the divide-by-zero early exit.
REQ-032 With RISCV_V_DIV_EARLY_ZERO_EN defined, an element with divisor zero SHALL skip ITER (PREP -> FIX) and cost 2 cycles; total latency becomes the sum of the per-element costs.
REQ-033 Without RISCV_V_DIV_EARLY_ZERO_EN, every element SHALL take W+2 cycles; latency is fixed per REQ-022 and results are identical in both builds.

Verification
REQ-034 8-bit, unsigned, quotient: all srca bytes 0x64, all srcb bytes 0x07 -> all result bytes 0x0E; out_valid at cycle 160 after accept.
REQ-035 32-bit, signed: lane0 srca 0xFFFFFFF9, srcb 0x00000002 -> quotient 0xFFFFFFFD; with is_rem, remainder 0xFFFFFFFF; latency 136.
REQ-036 16-bit, srcb = 0, srca lanes 0x1234 -> quotient lanes 0xFFFF; with is_rem, lanes 0x1234. With the macro defined, latency is 16 cycles.
REQ-037 64-bit, signed: srca 0x8000000000000000, srcb all-ones -> quotient 0x8000000000000000; remainder 0.
REQ-038 out_ready held 0 for 5 cycles after out_valid -> result stable and in_ready = 0; handshake -> in_ready = 1 on the next cycle.
REQ-039 rst_n = 0 at cycle 50 of an 8-bit operation -> next cycle out_valid = 0, in_ready = 1, result = 0; no stale out_valid afterward.
